// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle restoring divider: bus widths,
// FSM state encoding and the ready/start handshake levels.
package div_pkg;

   localparam int REG_W     = 32;
   localparam int DOUBLE_W  = 2 * REG_W;
   localparam int WORK_W    = DOUBLE_W + 1;
   localparam int DIV_STEPS = 32;
   localparam int CNT_W     = 6;

   typedef enum logic [1:0] {
      DIV_FREE    = 2'b00,
      DIV_BY_ZERO = 2'b01,
      DIV_ON      = 2'b10,
      DIV_END     = 2'b11
   } div_state_e;

   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;
   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div.sv
// 32/32 restoring divider, one quotient bit per cycle, result {remainder, quotient}.
// Define DIV_SIGNED_EN to honour signed_div_i; otherwise every division is unsigned.
module div
   import div_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                signed_div_i,
   input  logic [REG_W-1:0]    opdata1_i,
   input  logic [REG_W-1:0]    opdata2_i,
   input  logic                start_i,
   input  logic                annul_i,
   output logic [DOUBLE_W-1:0] result_o,
   output logic                ready_o
);

   div_state_e         state;
   div_state_e         state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [WORK_W-1:0]  dividend;
   logic [REG_W-1:0]   divisor;
   logic [REG_W+1:0]   diff;
   logic [REG_W-1:0]   op1_mag;
   logic [REG_W-1:0]   op2_mag;
   logic [REG_W-1:0]   quo_fin;
   logic [REG_W-1:0]   rem_fin;
   logic               req;
   logic               abort;
   logic               unused_diff_msb;

   assign req   = (start_i == DIV_START) && !annul_i;
   assign abort = annul_i || (start_i == DIV_STOP);

   // Upper 33 bits hold the shifted partial remainder plus the next dividend bit.
   assign diff            = {1'b0, dividend[WORK_W-1:REG_W]} - {2'b00, divisor};
   assign unused_diff_msb = diff[REG_W];

`ifdef DIV_SIGNED_EN
   logic neg_quo;
   logic neg_rem;

   function automatic logic [REG_W-1:0] neg32(input logic [REG_W-1:0] v);
      return ~v + 1'b1;
   endfunction

   assign op1_mag = (signed_div_i && opdata1_i[REG_W-1]) ? neg32(opdata1_i) : opdata1_i;
   assign op2_mag = (signed_div_i && opdata2_i[REG_W-1]) ? neg32(opdata2_i) : opdata2_i;
   assign quo_fin = neg_quo ? neg32(dividend[REG_W-1:0]) : dividend[REG_W-1:0];
   assign rem_fin = neg_rem ? neg32(dividend[WORK_W-1:REG_W+1]) : dividend[WORK_W-1:REG_W+1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         neg_quo <= 1'b0;
         neg_rem <= 1'b0;
      end else if (state == DIV_FREE && req) begin
         neg_quo <= signed_div_i && (opdata1_i[REG_W-1] ^ opdata2_i[REG_W-1]);
         neg_rem <= signed_div_i && opdata1_i[REG_W-1];
      end
   end
`else
   logic unused_signed_div;
   assign unused_signed_div = signed_div_i;
   assign op1_mag = opdata1_i;
   assign op2_mag = opdata2_i;
   assign quo_fin = dividend[REG_W-1:0];
   assign rem_fin = dividend[WORK_W-1:REG_W+1];
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= DIV_FREE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         DIV_FREE: begin
            if (req) state_nxt = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
         end
         DIV_BY_ZERO: begin
            state_nxt = abort ? DIV_FREE : DIV_END;
         end
         DIV_ON: begin
            if (abort)                                 state_nxt = DIV_FREE;
            else if (cnt == CNT_W'(DIV_STEPS - 1))     state_nxt = DIV_END;
         end
         DIV_END: begin
            if (start_i == DIV_STOP) state_nxt = DIV_FREE;
         end
         default: state_nxt = DIV_FREE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         dividend <= '0;
         divisor  <= '0;
         result_o <= '0;
         ready_o  <= DIV_RESULT_NOT_READY;
      end else begin
         case (state)
            DIV_FREE: begin
               ready_o  <= DIV_RESULT_NOT_READY;
               result_o <= '0;
               if (req) begin
                  cnt      <= '0;
                  divisor  <= op2_mag;
                  dividend <= (opdata2_i == '0) ? '0 : {{REG_W{1'b0}}, op1_mag, 1'b0};
               end
            end
            DIV_BY_ZERO: begin
               dividend <= '0;
               ready_o  <= DIV_RESULT_NOT_READY;
            end
            DIV_ON: begin
               ready_o <= DIV_RESULT_NOT_READY;
               if (abort) begin
                  cnt <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
                  if (diff[REG_W+1]) dividend <= {dividend[WORK_W-2:0], 1'b0};
                  else               dividend <= {diff[REG_W-1:0], dividend[REG_W-1:0], 1'b1};
               end
            end
            DIV_END: begin
               // Result is presented only while the requester keeps start asserted.
               if (start_i == DIV_STOP) begin
                  ready_o  <= DIV_RESULT_NOT_READY;
                  result_o <= '0;
               end else begin
                  ready_o  <= DIV_RESULT_READY;
                  result_o <= {rem_fin, quo_fin};
               end
            end
            default: ready_o <= DIV_RESULT_NOT_READY;
         endcase
      end
   end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: fixed vectors, hand-written corner sequences
// (annul, async reset, hold) and randomized requests against an arithmetic model.
module tb_div;

   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div;
   logic [31:0] op1;
   logic [31:0] op2;
   logic        start;
   logic        annul;
   logic [63:0] result;
   logic        ready;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   div dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div),
      .opdata1_i    (op1),
      .opdata2_i    (op2),
      .start_i      (start),
      .annul_i      (annul),
      .result_o     (result),
      .ready_o      (ready)
   );

   typedef struct {
      string       name;
      logic        s;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
      int          lat;
      int          hold;
   } vec_t;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, got, exp);
   endtask

   // Arithmetic reference: truncating division, remainder follows dividend sign.
   function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
      logic   use_signed;
      longint sa, sb, q, r;
      use_signed = s;
`ifndef DIV_SIGNED_EN
      use_signed = 1'b0;
`endif
      if (b == 0) return 64'd0;
      if (use_signed) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = sa / sb;
         r  = sa % sb;
         return {r[31:0], q[31:0]};
      end
      return {a % b, a / b};
   endfunction

   task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      signed_div = s;
      op1        = a;
      op2        = b;
      start      = 1'b1;
      @(posedge clk);
   endtask

   task automatic run_op(input string name, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat,
                         input int hold);
      int n;
      n = 0;
      issue(s, a, b);
      for (int k = 1; k <= 40 && n == 0; k++) begin
         @(posedge clk);
         #1;
         if (ready) n = k;
      end
      check({name, "_latency"}, 64'(n), 64'(lat));
      check({name, "_result"}, result, exp);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         check({name, "_hold_ready"}, 64'(ready), 64'd1);
         check({name, "_hold_result"}, result, exp);
      end
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      check({name, "_drop_ready"}, 64'(ready), 64'd0);
      check({name, "_drop_result"}, result, 64'd0);
   endtask

   vec_t vecs[7];

   initial begin
      logic        seen;
      logic        rs;
      logic [31:0] ra, rb;

      vecs[0] = '{"u100_7",   1'b0, 32'd100,       32'd7,         {32'd2, 32'd14},           33, 0};
      vecs[1] = '{"u9_3",     1'b0, 32'd9,         32'd3,         {32'd0, 32'd3},            33, 0};
      vecs[2] = '{"umax_1",   1'b0, 32'hFFFFFFFF,  32'd1,         {32'd0, 32'hFFFFFFFF},     33, 5};
      vecs[3] = '{"by_zero",  1'b1, 32'h12345678,  32'd0,         64'd0,                     2,  1};
      vecs[4] = '{"u_small",  1'b0, 32'd5,         32'd9,         {32'd5, 32'd0},            33, 0};
`ifdef DIV_SIGNED_EN
      vecs[5] = '{"s_m7_2",   1'b1, 32'hFFFFFFF9,  32'd2,         {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 0};
      vecs[6] = '{"s_min_m1", 1'b1, 32'h80000000,  32'hFFFFFFFF,  {32'd0, 32'h80000000},     33, 0};
`else
      vecs[5] = '{"s_m7_2",   1'b1, 32'hFFFFFFF9,  32'd2,         {32'd1, 32'h7FFFFFFC},     33, 0};
      vecs[6] = '{"s_min_m1", 1'b1, 32'h80000000,  32'hFFFFFFFF,  {32'h80000000, 32'd0},     33, 0};
`endif

      rst        = 1'b0;
      signed_div = 1'b0;
      op1        = '0;
      op2        = '0;
      start      = 1'b0;
      annul      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready", 64'(ready), 64'd0);
      check("reset_result", result, 64'd0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 7; i++)
         run_op(vecs[i].name, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].hold);

      // Annul mid-operation together with the request being withdrawn.
      seen = 1'b0;
      issue(1'b0, 32'd1000, 32'd3);
      for (int k = 1; k <= 40; k++) begin
         if (k == 10) begin
            @(negedge clk);
            annul = 1'b1;
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         if (k == 10) annul = 1'b0;
         if (ready) seen = 1'b1;
      end
      check("annul_no_ready", 64'(seen), 64'd0);
      run_op("after_annul_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 0);

      // Asynchronous reset in the middle of an operation.
      issue(1'b0, 32'd100, 32'd7);
      repeat (15) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("rst_mid_ready", 64'(ready), 64'd0);
      check("rst_mid_result", result, 64'd0);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      run_op("after_rst_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0);

      // Asynchronous reset while a result is being held.
      issue(1'b0, 32'd50, 32'd6);
      repeat (33) @(posedge clk);
      #1;
      check("hold_before_rst_ready", 64'(ready), 64'd1);
      check("hold_before_rst_result", result, {32'd2, 32'd8});
      #1;
      rst = 1'b0;
      #1;
      check("rst_end_ready", 64'(ready), 64'd0);
      check("rst_end_result", result, 64'd0);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 30; i++) begin
         rs = 1'($urandom_range(0, 1));
         ra = $urandom;
         case ($urandom_range(0, 5))
            0:       rb = 32'd0;
            1:       rb = $urandom_range(1, 255);
            2:       rb = 32'hFFFFFFFF - $urandom_range(0, 7);
            3:       begin ra = 32'h80000000; rb = $urandom; end
            default: rb = $urandom;
         endcase
         run_op($sformatf("rand%0d", i), rs, ra, rb, model(rs, ra, rb), (rb == 0) ? 2 : 33, 0);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 The block SHALL have one clock: clk, input, 1 bit, rising-edge active.
REQ-002 The block SHALL have one reset: rst, input, 1 bit, asynchronous, active-low (`RstEnable` = 1'b0).
REQ-003 signed_div_i  input  1  SHALL mean: 1 = signed division, 0 = unsigned.
REQ-004 opdata1_i  input  32 (`RegBus`)  SHALL carry the dividend.
REQ-005 opdata2_i  input  32 (`RegBus`)  SHALL carry the divisor.
REQ-006 start_i  input  1  SHALL be the request from the EX stage, held high until ready_o is seen.
REQ-007 annul_i  input  1  SHALL cancel an operation in progress (pipeline flush).
REQ-008 result_o  output  64 (`DoubleRegBus`)  SHALL be {remainder, quotient}, i.e. {HI, LO}.
REQ-009 ready_o  output  1  SHALL mean result_o is valid.

Function
REQ-010 The block SHALL be the responder to the EX-stage divide request; it SHALL hold four states: DivFree, DivByZero, DivOn, DivEnd.
REQ-011 DivFree: when start_i=1 and annul_i=0, the block SHALL move to DivByZero if opdata2_i==0, else load operands, clear the iteration count and move to DivOn.
REQ-012 DivOn SHALL run one restoring-division step per cycle over a 65-bit working register: subtract the divisor from the upper 33 bits, shift in 1 if non-negative, else shift in 0.
REQ-013 After exactly 32 steps, DivOn SHALL move to DivEnd.
REQ-014 Latency: start_i is sampled at edge E; ready_o=1 and result_o SHALL be valid from edge E+33.
REQ-015 DivByZero: the block SHALL move to DivEnd on the next edge with result 0; ready_o=1 from edge E+2.
REQ-016 DivEnd: ready_o and result_o SHALL hold while start_i=1; when start_i=0, the block SHALL return to DivFree with ready_o=0 and result_o=0 on the same edge.
REQ-017 annul_i=1 in DivOn or DivByZero SHALL return the block to DivFree on the next edge with ready_o=0 and no result.
REQ-018 annul_i=1 in DivEnd SHALL have no effect.
REQ-019 start_i=0 in DivOn SHALL be treated as annul.
REQ-020 Signed mode SHALL divide the magnitudes; the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the dividend's sign.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL produce quotient 0x80000000 and remainder 0.
REQ-022 In every state other than DivEnd, ready_o SHALL be 0.

Reset
REQ-023 rst=0 SHALL asynchronously force state DivFree, ready_o=0, result_o=0, iteration count 0 and working register 0, including mid-operation.
REQ-024 After reset release, the first start_i SHALL be handled as a fresh request.

Configuration
REQ-025 With DIV_SIGNED_EN defined, signed_div_i SHALL select signed division per REQ-020.
REQ-026 With DIV_SIGNED_EN undefined, signed_div_i SHALL be ignored, all divisions SHALL be unsigned and no negation logic SHALL be built.

Structure
REQ-027 The state encodings (DivFree, DivByZero, DivOn, DivEnd), DivResultReady/DivResultNotReady, DivStart/DivStop and `DoubleRegBus` SHALL live in define.v.
REQ-028 The block SHALL be a single module; the EX stage SHALL instantiate no sub-module of it, and div SHALL feed EX the result that EX forwards as hi_o/lo_o.

Verification
REQ-029 Unsigned 100/7 with start at edge E -> ready_o=1 at E+33, result_o={32'd2, 32'd14}.
REQ-030 Signed 0xFFFFFFF9/2 (-7/2) -> result_o={0xFFFFFFFF, 0xFFFFFFFD}; with DIV_SIGNED_EN undefined -> {0x1, 0x7FFFFFFC}.
REQ-031 Any/0 -> ready_o=1 at E+2, result_o=0; then start_i dropped -> ready_o=0 the next cycle.
REQ-032 annul_i pulsed at E+10 -> no ready_o through E+40; a new 9/3 request then -> {0, 3} after 33 cycles.
REQ-033 rst asserted at E+15 -> ready_o=0 and result_o=0 immediately (asynchronously); a request after release -> correct result.
REQ-034 Unsigned 0xFFFFFFFF/1 -> {0, 0xFFFFFFFF}; start_i held 5 cycles beyond ready -> result stable.
